// File: rtl/l1_rr_burst_arbiter.sv
// L1-to-L2 request arbiter: fixed-priority or round-robin grant, write bursts
// hold the L2 port until their last word, and read returns are routed by sub-ID.
module l1_rr_burst_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 30,
   parameter int DATA_W    = 32,
   parameter int SIZE_W    = 5,
   parameter int RR_MODE   = 1,
   parameter int SUB_ID_W  = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            req,
   input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
   input  logic [NUM_PORTS-1:0]            req_rnw,
   input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_be,
   input  logic [NUM_PORTS*SIZE_W-1:0]     req_size,
   input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
   input  logic [NUM_PORTS-1:0]            req_wvalid,
   output logic [NUM_PORTS-1:0]            ack,
   output logic [NUM_PORTS-1:0]            wack,
   input  logic                            l2_request_full,
   input  logic                            l2_data_full,
   output logic                            l2_request_push,
   output logic [ADDR_W-1:0]               l2_addr,
   output logic                            l2_rnw,
   output logic [DATA_W/8-1:0]             l2_be,
   output logic [SIZE_W-1:0]               l2_size,
   output logic [SUB_ID_W-1:0]             l2_sub_id,
   output logic                            l2_wr_data_push,
   output logic [DATA_W-1:0]               l2_wr_data,
   input  logic [DATA_W-1:0]               l2_rd_data,
   input  logic                            l2_rd_data_valid,
   input  logic [SUB_ID_W-1:0]             l2_rd_sub_id,
   output logic                            l2_rd_data_ack,
   output logic [DATA_W-1:0]               rsp_data,
   output logic [NUM_PORTS-1:0]            rsp_valid
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      WBURST = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [SUB_ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [SUB_ID_W-1:0] burst_port_q, burst_port_d;
   logic [SIZE_W-1:0]   burst_cnt_q, burst_cnt_d;

   logic [SUB_ID_W-1:0] grant_s;
   logic                grant_vld_s;
   logic                push_ready_s;

   logic [ADDR_W-1:0]   addr_a  [NUM_PORTS];
   logic [BE_W-1:0]     be_a    [NUM_PORTS];
   logic [SIZE_W-1:0]   size_a  [NUM_PORTS];
   logic [DATA_W-1:0]   wdata_a [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign addr_a[p]  = req_addr[p*ADDR_W +: ADDR_W];
      assign be_a[p]    = req_be[p*BE_W +: BE_W];
      assign size_a[p]  = req_size[p*SIZE_W +: SIZE_W];
      assign wdata_a[p] = req_wdata[p*DATA_W +: DATA_W];
   end

   assign push_ready_s = ~l2_request_full & ~l2_data_full;

   // Grant selection: first requester found scanning from index 0 or from rr_ptr with wrap.
   always_comb begin
      logic [SUB_ID_W-1:0] idx_s;
      grant_vld_s = 1'b0;
      grant_s     = '0;
      idx_s       = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (RR_MODE != 0) begin
            idx_s = SUB_ID_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
         end else begin
            idx_s = SUB_ID_W'(k);
         end
         if (!grant_vld_s && req[idx_s]) begin
            grant_vld_s = 1'b1;
            grant_s     = idx_s;
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   // Next-state and grant outputs; everything handshaking is forced low during reset.
   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      burst_port_d    = burst_port_q;
      burst_cnt_d     = burst_cnt_q;
      ack             = '0;
      wack            = '0;
      l2_request_push = 1'b0;
      l2_wr_data_push = 1'b0;
      l2_addr         = addr_a[grant_s];
      l2_rnw          = req_rnw[grant_s];
      l2_be           = be_a[grant_s];
      l2_size         = size_a[grant_s];
      l2_sub_id       = grant_s;
      l2_wr_data      = wdata_a[grant_s];

      case (state_q)
         IDLE: begin
            if (!rst && grant_vld_s && push_ready_s) begin
               l2_request_push = 1'b1;
               ack[grant_s]    = 1'b1;
               if (RR_MODE != 0) begin
                  rr_ptr_d = SUB_ID_W'((int'(grant_s) + 1) % NUM_PORTS);
               end else begin
                  rr_ptr_d = rr_ptr_q;
               end
               if (!req_rnw[grant_s]) begin
                  // Word 1 travels with the command; only S>0 needs the burst state.
                  l2_wr_data_push = 1'b1;
                  if (size_a[grant_s] != '0) begin
                     state_d      = WBURST;
                     burst_port_d = grant_s;
                     burst_cnt_d  = size_a[grant_s];
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end

         WBURST: begin
            l2_wr_data = wdata_a[burst_port_q];
            if (!rst && req_wvalid[burst_port_q] && !l2_data_full) begin
               l2_wr_data_push    = 1'b1;
               wack[burst_port_q] = 1'b1;
               burst_cnt_d        = burst_cnt_q - SIZE_W'(1);
               if (burst_cnt_q <= SIZE_W'(1)) begin
                  state_d = IDLE;
               end else begin
                  state_d = WBURST;
               end
            end else begin
               state_d = WBURST;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         burst_port_q <= '0;
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         burst_port_q <= burst_port_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   assign l2_rd_data_ack = l2_rd_data_valid;
   assign rsp_data       = l2_rd_data;

   // Return routing: an out-of-range sub-ID matches no port.
   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rsp_valid[i] = l2_rd_data_valid && (int'(l2_rd_sub_id) == i);
      end
   end

endmodule

// File: tb/tb_l1_rr_burst_arbiter.sv
// Directed plus random bench: a round-robin and a fixed-priority instance share
// one stimulus and are both compared with a word-count reference model.
module tb_l1_rr_burst_arbiter;

   localparam int N  = 4;
   localparam int AW = 30;
   localparam int DW = 32;
   localparam int SW = 5;
   localparam int BW = DW / 8;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_rnw;
   logic [N*BW-1:0] req_be;
   logic [N*SW-1:0] req_size;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_wvalid;
   logic            l2_request_full;
   logic            l2_data_full;
   logic [DW-1:0]   l2_rd_data;
   logic            l2_rd_data_valid;
   logic [IW-1:0]   l2_rd_sub_id;

   logic [N-1:0]    ack_w      [2];
   logic [N-1:0]    wack_w     [2];
   logic            push_w     [2];
   logic [AW-1:0]   addr_w     [2];
   logic            rnw_w      [2];
   logic [BW-1:0]   be_w       [2];
   logic [SW-1:0]   size_w     [2];
   logic [IW-1:0]   sub_w      [2];
   logic            wpush_w    [2];
   logic [DW-1:0]   wdata_w    [2];
   logic            rdack_w    [2];
   logic [DW-1:0]   rspdata_w  [2];
   logic [N-1:0]    rspvalid_w [2];

   int checks = 0;
   int errors = 0;

   // reference model: words still owed by an open burst, its port, RR start point
   int rem_q [2];
   int bp_q  [2];
   int ptr_q [2];
   int rem_n [2];
   int bp_n  [2];
   int ptr_n [2];
   string mname [2] = '{"rr", "fp"};

   always #5 clk = ~clk;

   l1_rr_burst_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .RR_MODE(1)) dut_rr (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rnw(req_rnw), .req_be(req_be),
      .req_size(req_size), .req_wdata(req_wdata), .req_wvalid(req_wvalid),
      .ack(ack_w[0]), .wack(wack_w[0]),
      .l2_request_full(l2_request_full), .l2_data_full(l2_data_full),
      .l2_request_push(push_w[0]), .l2_addr(addr_w[0]), .l2_rnw(rnw_w[0]), .l2_be(be_w[0]),
      .l2_size(size_w[0]), .l2_sub_id(sub_w[0]), .l2_wr_data_push(wpush_w[0]), .l2_wr_data(wdata_w[0]),
      .l2_rd_data(l2_rd_data), .l2_rd_data_valid(l2_rd_data_valid), .l2_rd_sub_id(l2_rd_sub_id),
      .l2_rd_data_ack(rdack_w[0]), .rsp_data(rspdata_w[0]), .rsp_valid(rspvalid_w[0])
   );

   l1_rr_burst_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .RR_MODE(0)) dut_fp (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rnw(req_rnw), .req_be(req_be),
      .req_size(req_size), .req_wdata(req_wdata), .req_wvalid(req_wvalid),
      .ack(ack_w[1]), .wack(wack_w[1]),
      .l2_request_full(l2_request_full), .l2_data_full(l2_data_full),
      .l2_request_push(push_w[1]), .l2_addr(addr_w[1]), .l2_rnw(rnw_w[1]), .l2_be(be_w[1]),
      .l2_size(size_w[1]), .l2_sub_id(sub_w[1]), .l2_wr_data_push(wpush_w[1]), .l2_wr_data(wdata_w[1]),
      .l2_rd_data(l2_rd_data), .l2_rd_data_valid(l2_rd_data_valid), .l2_rd_sub_id(l2_rd_sub_id),
      .l2_rd_data_ack(rdack_w[1]), .rsp_data(rspdata_w[1]), .rsp_valid(rspvalid_w[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      req = '0; req_addr = '0; req_rnw = '0; req_be = '0; req_size = '0;
      req_wdata = '0; req_wvalid = '0; l2_request_full = 1'b0; l2_data_full = 1'b0;
      l2_rd_data = '0; l2_rd_data_valid = 1'b0; l2_rd_sub_id = '0;
   endtask

   task automatic model_check();
      for (int m = 0; m < 2; m++) begin
         logic         e_push, e_wpush;
         logic [N-1:0] e_ack, e_wack, e_rsp;
         logic [DW-1:0] e_wdata;
         int g, start;
         e_push = 1'b0; e_wpush = 1'b0; e_ack = '0; e_wack = '0; e_wdata = '0; g = -1;
         rem_n[m] = rem_q[m]; bp_n[m] = bp_q[m]; ptr_n[m] = ptr_q[m];
         if (rst) begin
            rem_n[m] = 0; bp_n[m] = 0; ptr_n[m] = 0;
         end else if (rem_q[m] > 0) begin
            e_wpush = req_wvalid[bp_q[m]] & ~l2_data_full;
            e_wack  = e_wpush ? (N'(1) << bp_q[m]) : '0;
            e_wdata = req_wdata[bp_q[m]*DW +: DW];
            if (e_wpush) rem_n[m] = rem_q[m] - 1;
         end else begin
            start = (m == 0) ? ptr_q[m] : 0;
            for (int k = 0; k < N; k++) begin
               if (g < 0 && req[(start + k) % N]) g = (start + k) % N;
            end
            if (g >= 0 && !l2_request_full && !l2_data_full) begin
               e_push = 1'b1;
               e_ack  = N'(1) << g;
               if (m == 0) ptr_n[m] = (g + 1) % N;
               if (!req_rnw[g]) begin
                  e_wpush = 1'b1;
                  e_wdata = req_wdata[g*DW +: DW];
                  if (req_size[g*SW +: SW] != 0) begin
                     rem_n[m] = int'(req_size[g*SW +: SW]);
                     bp_n[m]  = g;
                  end
               end
            end
         end
         chk({mname[m], "_push"}, 64'(push_w[m]), 64'(e_push));
         chk({mname[m], "_ack"}, 64'(ack_w[m]), 64'(e_ack));
         chk({mname[m], "_wack"}, 64'(wack_w[m]), 64'(e_wack));
         chk({mname[m], "_wpush"}, 64'(wpush_w[m]), 64'(e_wpush));
         if (e_push) begin
            chk({mname[m], "_addr"}, 64'(addr_w[m]), 64'(req_addr[g*AW +: AW]));
            chk({mname[m], "_rnw"}, 64'(rnw_w[m]), 64'(req_rnw[g]));
            chk({mname[m], "_be"}, 64'(be_w[m]), 64'(req_be[g*BW +: BW]));
            chk({mname[m], "_size"}, 64'(size_w[m]), 64'(req_size[g*SW +: SW]));
            chk({mname[m], "_subid"}, 64'(sub_w[m]), 64'(g));
         end
         if (e_wpush) chk({mname[m], "_wdata"}, 64'(wdata_w[m]), 64'(e_wdata));
         e_rsp = (l2_rd_data_valid && int'(l2_rd_sub_id) < N) ? (N'(1) << l2_rd_sub_id) : '0;
         chk({mname[m], "_rspvalid"}, 64'(rspvalid_w[m]), 64'(e_rsp));
         chk({mname[m], "_rdack"}, 64'(rdack_w[m]), 64'(l2_rd_data_valid));
         if (l2_rd_data_valid) chk({mname[m], "_rspdata"}, 64'(rspdata_w[m]), 64'(l2_rd_data));
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         rem_q[m] = rem_n[m]; bp_q[m] = bp_n[m]; ptr_q[m] = ptr_n[m];
      end
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         rem_q[m] = 0; bp_q[m] = 0; ptr_q[m] = 0;
      end
      clr();
      rst = 1'b1;
      req = 4'b1111; req_rnw = 4'b1111;
      settle();
      chk("rst_ack", 64'(ack_w[0]), 64'h0);
      chk("rst_push", 64'(push_w[1]), 64'h0);
      advance();
      rst = 1'b0;

      // all four requesting in RR mode: grants rotate 0,1,2,3,0
      for (int c = 0; c < 5; c++) begin
         settle();
         chk("rot_ack_rr", 64'(ack_w[0]), 64'(4'b0001) << (c % 4));
         chk("rot_ack_fp", 64'(ack_w[1]), 64'h1);
         advance();
      end

      // fixed priority with ports 1 and 3 requesting: port 1 always wins
      req = 4'b1010;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("fp_ack", 64'(ack_w[1]), 64'b0010);
         advance();
      end

      // port 2 write burst of 4 words, port 0 reading throughout, one data stall
      clr();
      req = 4'b0101; req_rnw = 4'b0001;
      req_size[2*SW +: SW] = 5'd3;
      req_wdata[2*DW +: DW] = 32'hA0A0_0000;
      settle();
      chk("b0_ack", 64'(ack_w[0]), 64'b0100);
      chk("b0_sub", 64'(sub_w[0]), 64'd2);
      chk("b0_size", 64'(size_w[0]), 64'd3);
      chk("b0_wdata", 64'(wdata_w[0]), 64'hA0A0_0000);
      advance();
      req = 4'b0001; req_wvalid = 4'b0100;
      req_wdata[2*DW +: DW] = 32'hA1A1_0001;
      settle();
      chk("b1_ack", 64'(ack_w[0]), 64'h0);
      chk("b1_wack", 64'(wack_w[0]), 64'b0100);
      chk("b1_wdata", 64'(wdata_w[0]), 64'hA1A1_0001);
      advance();
      req_wdata[2*DW +: DW] = 32'hA2A2_0002;
      l2_data_full = 1'b1;
      settle();
      chk("b2_stall_wpush", 64'(wpush_w[0]), 64'h0);
      chk("b2_stall_ack", 64'(ack_w[0]), 64'h0);
      advance();
      l2_data_full = 1'b0;
      settle();
      chk("b3_wdata", 64'(wdata_w[0]), 64'hA2A2_0002);
      chk("b3_ack", 64'(ack_w[0]), 64'h0);
      advance();
      req_wdata[2*DW +: DW] = 32'hA3A3_0003;
      settle();
      chk("b4_wdata", 64'(wdata_w[0]), 64'hA3A3_0003);
      chk("b4_wack", 64'(wack_w[0]), 64'b0100);
      advance();
      req_wvalid = '0;
      settle();
      chk("b5_ack", 64'(ack_w[0]), 64'b0001);
      advance();

      // request FIFO full holds off the grant
      clr();
      req = 4'b0001; req_rnw = 4'b1111; l2_request_full = 1'b1;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk("full_ack", 64'(ack_w[0]), 64'h0);
         chk("full_push", 64'(push_w[1]), 64'h0);
         advance();
      end
      l2_request_full = 1'b0;
      settle();
      chk("unfull_ack_rr", 64'(ack_w[0]), 64'b0001);
      chk("unfull_ack_fp", 64'(ack_w[1]), 64'b0001);
      advance();

      // read return routed to port 3
      clr();
      l2_rd_data_valid = 1'b1; l2_rd_sub_id = 2'd3; l2_rd_data = 32'hDEAD_BEEF;
      settle();
      chk("ret_valid", 64'(rspvalid_w[0]), 64'b1000);
      chk("ret_data", 64'(rspdata_w[1]), 64'hDEAD_BEEF);
      chk("ret_ack", 64'(rdack_w[0]), 64'h1);
      advance();

      // reset in the middle of a port 1 burst
      clr();
      req = 4'b0010; req_size[1*SW +: SW] = 5'd3; req_wdata[1*DW +: DW] = 32'h1111_0000;
      settle();
      chk("rb_ack", 64'(ack_w[0]), 64'b0010);
      advance();
      req = '0; req_wvalid = 4'b0010; req_wdata[1*DW +: DW] = 32'h1111_0001;
      settle();
      chk("rb_wpush", 64'(wpush_w[1]), 64'h1);
      advance();
      rst = 1'b1; req = 4'b0010;
      settle();
      chk("rb_rst_wpush", 64'(wpush_w[0]), 64'h0);
      chk("rb_rst_wack", 64'(wack_w[1]), 64'h0);
      chk("rb_rst_push", 64'(push_w[0]), 64'h0);
      chk("rb_rst_ack", 64'(ack_w[1]), 64'h0);
      advance();
      rst = 1'b0; req_wvalid = '0; req = 4'b1010; req_rnw = 4'b1111;
      settle();
      chk("post_rst_ack_rr", 64'(ack_w[0]), 64'b0010);
      chk("post_rst_ack_fp", 64'(ack_w[1]), 64'b0010);
      advance();

      // random traffic, occasional back-pressure and reset
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         req = N'($urandom); req_rnw = N'($urandom); req_wvalid = N'($urandom);
         for (int p = 0; p < N; p++) begin
            req_addr[p*AW +: AW]  = AW'($urandom);
            req_be[p*BW +: BW]    = BW'($urandom);
            req_size[p*SW +: SW]  = SW'($urandom_range(0, 3));
            req_wdata[p*DW +: DW] = $urandom;
         end
         l2_request_full  = ($urandom_range(0, 4) == 0);
         l2_data_full     = ($urandom_range(0, 4) == 0);
         l2_rd_data_valid = $urandom_range(0, 1) == 1;
         l2_rd_sub_id     = IW'($urandom);
         l2_rd_data       = $urandom;
         settle();
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/l1_rr_burst_arbiter.md
# l1_rr_burst_arbiter

Parametrised L1-to-L2 request arbiter that multiplexes NUM_PORTS L1 requesters (data cache, instruction cache, MMUs, future cores) onto one L2 requester port. It supports fixed-priority or round-robin selection and locks the grant across multi-word write bursts. It routes L2 read returns back to the originating port by sub-ID. It sits between the L1 units and the L2 request/data FIFOs, in the same position as the single-word arbiter it supersedes.

## Interface
Parameters:
- NUM_PORTS, 4, number of L1 requesters; port 0 is index 0 of every packed vector
- ADDR_W, 30, word address width
- DATA_W, 32, data word width
- SIZE_W, 5, burst-size field width; a request of size S transfers S+1 words
- RR_MODE, 1, 0 = fixed priority (port 0 highest), 1 = round robin
- SUB_ID_W, $clog2(NUM_PORTS), sub-ID width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_PORTS  per-port request valid
- req_addr  in  NUM_PORTS*ADDR_W  per-port word address
- req_rnw  in  NUM_PORTS  1 = read
- req_be  in  NUM_PORTS*(DATA_W/8)  byte enables
- req_size  in  NUM_PORTS*SIZE_W  burst size S
- req_wdata  in  NUM_PORTS*DATA_W  current write data word
- req_wvalid  in  NUM_PORTS  write word valid, used only for words 2..S+1
- ack  out  NUM_PORTS  request accepted; carries word 1 for writes
- wack  out  NUM_PORTS  burst data word 2..S+1 accepted
- l2_request_full  in  1  L2 address FIFO full
- l2_data_full  in  1  L2 write-data FIFO full
- l2_request_push  out  1  push address/command
- l2_addr, l2_rnw, l2_be, l2_size, l2_sub_id  out  ADDR_W/1/DATA_W/8/SIZE_W/SUB_ID_W  command fields
- l2_wr_data_push  out  1  push write data
- l2_wr_data  out  DATA_W  write data
- l2_rd_data  in  DATA_W  returned read data
- l2_rd_data_valid  in  1  return valid
- l2_rd_sub_id  in  SUB_ID_W  return destination
- l2_rd_data_ack  out  1  equals l2_rd_data_valid
- rsp_data  out  DATA_W  broadcast l2_rd_data
- rsp_valid  out  NUM_PORTS  rsp_valid[i] = l2_rd_data_valid & (l2_rd_sub_id == i)

## Operation
- State register: IDLE, WBURST. Also rr_ptr (SUB_ID_W), burst_port (SUB_ID_W), burst_cnt (SIZE_W).
- push_ready = ~l2_request_full & ~l2_data_full.
- IDLE: the grant g is the first asserted req scanning from index 0 (RR_MODE=0), or from rr_ptr upward with wrap past NUM_PORTS-1 to 0 (RR_MODE=1).
  - If any req is asserted and push_ready is high: l2_request_push=1, ack[g]=1, and the command fields come from port g with l2_sub_id=g.
  - If port g is a write: l2_wr_data_push=1 with req_wdata[g].
- Fire cycle:
  - rr_ptr <= (g+1) mod NUM_PORTS; it updates only on a fire, and only in RR_MODE=1.
  - If the request is a write with S>0: burst_port<=g, burst_cnt<=S, state<=WBURST.
- WBURST:
  - l2_request_push=0 and all ack=0; other ports are held off.
  - l2_wr_data_push = wack[burst_port] = req_wvalid[burst_port] & ~l2_data_full, with l2_wr_data=req_wdata[burst_port].
  - Each push decrements burst_cnt. The push made while burst_cnt==1 returns state to IDLE.
- A read of any size, or a write with S=0, completes in IDLE with no state change.
- Return path is combinational and independent of state; returns are accepted every cycle. A sub_id ≥ NUM_PORTS asserts no rsp_valid.
- Outputs not being driven by a grant are 0 (push, ack, wack). Command fields are don't-care when l2_request_push=0.

## Timing
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, burst_port=0, burst_cnt=0. All ack/wack/push outputs are combinationally 0 while rst is high.
- Zero-cycle latency: ack and push are in the same cycle as req when push_ready is high. The requester drops or advances req on the cycle after ack.
- A write of S+1 words occupies the L2 port for at least S+1 cycles. No command is interleaved.
- l2_data_full stalls a burst word without losing it; req_wvalid must hold until wack.
- With req and l2_rd_data_valid simultaneous, both proceed independently.
- Reset mid-burst aborts the burst; the L2 side is reset with the arbiter.

## Test plan
- RR_MODE=1, NUM_PORTS=4, req=4'b1111 held, no back-pressure -> grants 0,1,2,3,0 on consecutive cycles; rr_ptr sequence 1,2,3,0,1.
- RR_MODE=0, req=4'b1010 for 3 cycles -> ack[1] each cycle, ack[3] never.
- Port 2 write, S=3, data A0..A3; l2_data_full high on the 2nd burst cycle; port 0 requesting throughout -> pushes A0 (with command), A1, stall, A2, A3; port 0 acked on the cycle after A3 pushes.
- l2_request_full=1 with req=4'b0001 -> no ack, no push; full drops -> ack[0] the same cycle.
- l2_rd_data_valid=1, l2_rd_sub_id=3, data 0xDEADBEEF -> rsp_valid=4'b1000, rsp_data=0xDEADBEEF, l2_rd_data_ack=1.
- rst asserted with burst_cnt=2 in WBURST -> outputs 0 immediately; after release state=IDLE, rr_ptr=0, and a fresh req[1] is acked.
